// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared constants and types for the binary16 normalize/round pipeline.
//   EXP_BIAS / EXP_MAX / MANT_W : binary16 format parameters
//   SIG_W  : significand width including the hidden bit
//   VEC_W  : significand plus guard/round/sticky
//   LZC_W  : width of the leading-zero count from lzd
//   fp16_flags_t : {overflow, underflow, inexact}, MSB first
//   round_up()   : round-to-nearest-even increment decision
// ---------------------------------------------------------------------------
package fp16_pkg;

    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;
    localparam int MANT_W   = 10;
    localparam int SIG_W    = MANT_W + 1;
    localparam int VEC_W    = SIG_W + 3;
    localparam int LZC_W    = 4;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp16_flags_t;

    // Round to nearest, ties to even: bump when above half, or exactly half
    // with an odd kept LSB.
    function automatic logic round_up(input logic g, input logic s, input logic lsb);
        return g & (s | lsb);
    endfunction

endpackage

// File: rtl/fp16_norm_round_lzd.sv
// ---------------------------------------------------------------------------
// lzd -- leading-zero detector for an 11-bit significand.
// Ports:
//   data_i [10:0] : value to scan
//   lzc_o  [3:0]  : number of zeros above the most significant 1 (11 when zero)
//   zero_o        : data_i is all zeros
// ---------------------------------------------------------------------------
module lzd (
    input  logic [10:0] data_i,
    output logic [3:0]  lzc_o,
    output logic        zero_o
);

    // Scan upward so the highest set bit is the last one to write lzc_o.
    always_comb begin
        lzc_o = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (data_i[i]) begin
                lzc_o = 4'(10 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fp16_norm_round.sv
// ---------------------------------------------------------------------------
// fp16_norm_round
// Two-stage valid/ready pipeline that normalizes an unnormalized significand
// and rounds it (nearest-even) into an IEEE binary16 result.
//   Stage 1: leading-zero count, left shift of {mant,grs}, exponent adjust.
//   Stage 2: rounding, overflow/underflow handling, result/flag registers.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready combinational from out_ready)
//   in_sign, in_exp[6:0], in_mant[10:0], in_grs[2:0]
//                       : sign, two's-complement exponent of in_mant[10],
//                         significand, guard/round/sticky
//   out_valid / out_ready : output handshake
//   out_result[15:0]    : binary16 result
//   out_flags[2:0]      : {overflow, underflow, inexact} for this beat
// Configuration:
//   FP16_NORM_SUBNORM_EN : when defined, tiny results are denormalized and
//                          rounded; otherwise they flush to signed zero.
// ---------------------------------------------------------------------------
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [10:0] in_mant,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_flags
);

    localparam logic signed [7:0] E_MAX = 8'(EXP_MAX);

    // ---------------- handshake ----------------
    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv, accept;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    // ---------------- stage 1: normalize ----------------
    logic [LZC_W-1:0]   lzc;
    logic               mant_zero;
    logic [VEC_W-1:0]   s1_sig_d, s1_sig_q;
    logic signed [7:0]  s1_exp_d, s1_exp_q;
    logic               s1_sign_q, s1_zero_q;

    lzd u_lzd (
        .data_i (in_mant),
        .lzc_o  (lzc),
        .zero_o (mant_zero)
    );

    assign s1_sig_d = {in_mant, in_grs} << lzc;
    assign s1_exp_d = $signed({in_exp[6], in_exp}) - $signed({4'b0, lzc});

    // ---------------- stage 2: round and pack ----------------
    logic [SIG_W:0]     norm_sum;
    logic signed [7:0]  exp_rnd;
    logic               norm_g, norm_s, norm_up;
    logic [15:0]        s2_result_d, s2_result_q;
    fp16_flags_t        s2_flags_d, s2_flags_q;

`ifdef FP16_NORM_SUBNORM_EN
    // Denormalize by 1-e; anything shifted past the vector folds into sticky.
    logic signed [7:0]  sub_dist;
    logic [3:0]         sub_sh;
    logic [VEC_W-1:0]   sub_sig, sub_lost;
    logic               sub_g, sub_s, sub_up;
    logic [SIG_W-1:0]   sub_sum;

    assign sub_dist = 8'sd1 - s1_exp_q;
    assign sub_sh   = (sub_dist > 8'sd14) ? 4'd14 : sub_dist[3:0];
    assign sub_sig  = s1_sig_q >> sub_sh;
    assign sub_lost = s1_sig_q & ~({VEC_W{1'b1}} << sub_sh);
    assign sub_g    = sub_sig[2];
    assign sub_s    = (|sub_sig[1:0]) | (|sub_lost);
    assign sub_up   = round_up(sub_g, sub_s, sub_sig[3]);
    // Top bit is always 0 after a shift of at least 1, so no carry-out; a sum
    // of 0x400 lands in the exponent field as the smallest normal.
    assign sub_sum  = sub_sig[VEC_W-1:3] + {{(SIG_W-1){1'b0}}, sub_up};
`endif

    // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
    always_comb begin
        s2_result_d = '0;
        s2_flags_d  = '0;

        norm_g   = s1_sig_q[2];
        norm_s   = |s1_sig_q[1:0];
        norm_up  = round_up(norm_g, norm_s, s1_sig_q[3]);
        norm_sum = {1'b0, s1_sig_q[VEC_W-1:3]} + {{SIG_W{1'b0}}, norm_up};
        // A carry out of the significand leaves the fraction bits zero and
        // bumps the exponent.
        exp_rnd  = s1_exp_q + {7'b0, norm_sum[SIG_W]};

        if (s1_zero_q) begin
            s2_result_d = {s1_sign_q, 15'b0};
        end else if (s1_exp_q >= E_MAX) begin
            s2_result_d         = {s1_sign_q, 5'h1F, 10'h0};
            s2_flags_d.overflow = 1'b1;
            s2_flags_d.inexact  = 1'b1;
        end else if (s1_exp_q >= 8'sd1) begin
            if (exp_rnd >= E_MAX) begin
                s2_result_d         = {s1_sign_q, 5'h1F, 10'h0};
                s2_flags_d.overflow = 1'b1;
                s2_flags_d.inexact  = 1'b1;
            end else begin
                s2_result_d        = {s1_sign_q, exp_rnd[4:0], norm_sum[MANT_W-1:0]};
                s2_flags_d.inexact = norm_g | norm_s;
            end
        end else begin
`ifdef FP16_NORM_SUBNORM_EN
            s2_result_d          = {s1_sign_q, 4'b0, sub_sum};
            s2_flags_d.inexact   = sub_g | sub_s;
            s2_flags_d.underflow = sub_g | sub_s;
`else
            s2_result_d          = {s1_sign_q, 15'b0};
            s2_flags_d.inexact   = 1'b1;
            s2_flags_d.underflow = 1'b1;
`endif
        end
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            // NOTE: datapath registers are reset as well because the outputs must read zero during reset.
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_sig_q    <= '0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_sign_q <= in_sign;
                s1_zero_q <= mant_zero;
                s1_exp_q  <= s1_exp_d;
                s1_sig_q  <= s1_sig_d;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            // Output data only changes when a new beat moves in, so it holds
            // while the consumer stalls.
            if (s2_adv && s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_flags_q  <= s2_flags_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;

endmodule

// File: tb/tb_fp16_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp16_norm_round
// Self-checking bench for fp16_norm_round. Expected results come from an
// arithmetic model: the input is the integer {mant,grs} scaled by
// 2^(exp-28), rounded to the binary16 quantum with exact remainder math.
// Honours FP16_NORM_SUBNORM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fp16_norm_round;
    import fp16_pkg::*;

    typedef struct packed {
        logic        s;
        logic [6:0]  e;
        logic [10:0] m;
        logic [2:0]  g;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;
    beat_t       cur;

    always #5 clk = ~clk;

    fp16_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (cur.s),
        .in_exp     (cur.e),
        .in_mant    (cur.m),
        .in_grs     (cur.g),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic beat_t mk(input logic s, input logic [6:0] e, input logic [10:0] m, input logic [2:0] g);
        beat_t b;
        b.s = s; b.e = e; b.m = m; b.g = g;
        return b;
    endfunction

    // Returns {result[15:0], flags[2:0]}.
    function automatic logic [18:0] model(input beat_t b);
        int          x, p, ex, eb, sh, drop;
        longint      q, rem, half;
        logic        inexact;
        x = {18'b0, b.m, b.g};
        ex = $signed(b.e);
        if (b.m == 11'd0) return {b.s, 15'b0, 3'b000};
        p = 13;
        while (x[p] == 1'b0) p--;
        eb = ex - (13 - p);                  // biased exponent of the leading 1
        if (eb >= EXP_MAX) return {b.s, 5'h1F, 10'h0, 3'b101};
        // Quantum is 2^(max(eb,1)-25); value is x * 2^(ex-28).
        sh = ex - 3 - ((eb >= 1) ? eb : 1);
        if (sh >= 0) begin
            q = longint'(x) << sh; rem = 0; half = 1;
        end else begin
            drop = -sh;
            if (drop > 30) begin
                q = 0; rem = x; half = longint'(1) << 30;
            end else begin
                q = longint'(x) >> drop;
                rem = longint'(x) - (q << drop);
                half = longint'(1) << (drop - 1);
            end
        end
        inexact = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (eb >= 1) begin
            if (q == 2048) begin q = 1024; eb++; end
            if (eb >= EXP_MAX) return {b.s, 5'h1F, 10'h0, 3'b101};
            return {b.s, eb[4:0], q[9:0], 2'b00, inexact};
        end
`ifdef FP16_NORM_SUBNORM_EN
        return {b.s, 15'(q), 1'b0, inexact, inexact};
`else
        return {b.s, 15'b0, 3'b011};
`endif
    endfunction

    // ---------------- compare process ----------------
    logic        held = 1'b0;
    logic [18:0] held_val;
    logic [18:0] exp_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model(cur));
            if (out_valid && !out_ready) begin
                if (held) check("hold_stable", {13'b0, out_result, out_flags}, {13'b0, held_val});
                held = 1'b1;
                held_val = {out_result, out_flags};
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got %h with no beat outstanding at %0t", out_result, $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("result", {16'b0, out_result}, {16'b0, exp_e[18:3]});
                    check("flags", {29'b0, out_flags}, {29'b0, exp_e[2:0]});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Single beat with an idle pipeline: checks exact 2-cycle latency and a literal result.
    task automatic direct(input string name, input beat_t b, input logic [15:0] r, input logic [2:0] f);
        out_ready = 1'b1;
        cur = b;
        in_valid = 1'b1;
        #1;
        check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat1"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({name, "_lat2"}, {31'b0, out_valid}, 32'd1);
        check({name, "_res"}, {16'b0, out_result}, {16'b0, r});
        check({name, "_flg"}, {29'b0, out_flags}, {29'b0, f});
        @(posedge clk); #1;
    endtask

    task automatic push(input beat_t b);
        logic acc;
        acc = 1'b0;
        cur = b;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("push_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    beat_t vecs [16];

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cur = '0;

        // Pin the model to hand-computed values.
        check("model_one", {13'b0, model(mk(1'b0, 7'(EXP_BIAS), 11'h400, 3'b000))}, {13'b0, 16'h3C00, 3'b000});
        check("model_tie_carry", {13'b0, model(mk(1'b0, 7'd15, 11'h7FF, 3'b100))}, {13'b0, 16'h4000, 3'b001});
        check("model_ovf", {13'b0, model(mk(1'b1, 7'd30, 11'h7FF, 3'b110))}, {13'b0, 16'hFC00, 3'b101});
`ifdef FP16_NORM_SUBNORM_EN
        check("model_tiny", {13'b0, model(mk(1'b0, 7'd0, 11'h400, 3'b001))}, {13'b0, 16'h0200, 3'b011});
`else
        check("model_tiny", {13'b0, model(mk(1'b0, 7'd0, 11'h400, 3'b001))}, {13'b0, 16'h0000, 3'b011});
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", {16'b0, out_result}, 32'd0);
        check("rst_flags", {29'b0, out_flags}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with literal expectations.
        direct("one",       mk(1'b0, 7'd15, 11'h400, 3'b000), 16'h3C00, 3'b000);
        direct("lzc10",     mk(1'b0, 7'd15, 11'h001, 3'b000), 16'h1400, 3'b000);
        direct("tie_carry", mk(1'b0, 7'd15, 11'h7FF, 3'b100), 16'h4000, 3'b001);
        direct("tie_even",  mk(1'b0, 7'd15, 11'h400, 3'b100), 16'h3C00, 3'b001);
        direct("ovf_pos",   mk(1'b0, 7'd30, 11'h7FF, 3'b110), 16'h7C00, 3'b101);
        direct("ovf_neg",   mk(1'b1, 7'd30, 11'h7FF, 3'b110), 16'hFC00, 3'b101);
        direct("max_norm",  mk(1'b0, 7'd30, 11'h7FF, 3'b000), 16'h7BFF, 3'b000);
        direct("e31",       mk(1'b0, 7'd31, 11'h400, 3'b000), 16'h7C00, 3'b101);
        direct("lzc_e30",   mk(1'b0, 7'd40, 11'h001, 3'b000), 16'h7800, 3'b000);
        direct("min_norm",  mk(1'b0, 7'd1,  11'h400, 3'b000), 16'h0400, 3'b000);
        direct("zero_neg",  mk(1'b1, 7'd5,  11'h000, 3'b111), 16'h8000, 3'b000);
`ifdef FP16_NORM_SUBNORM_EN
        direct("tiny",      mk(1'b0, 7'd0,  11'h400, 3'b001), 16'h0200, 3'b011);
        direct("tiny_up",   mk(1'b0, 7'd0,  11'h7FF, 3'b111), 16'h0400, 3'b011);
`else
        direct("tiny",      mk(1'b0, 7'd0,  11'h400, 3'b001), 16'h0000, 3'b011);
        direct("tiny_up",   mk(1'b0, 7'd0,  11'h7FF, 3'b111), 16'h0000, 3'b011);
`endif

        // Backpressure: three beats, out_ready low for four cycles.
        out_ready = 1'b0;
        cur = mk(1'b0, 7'd16, 11'h400, 3'b000); in_valid = 1'b1; #1;
        check("bp_ready0", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        cur = mk(1'b1, 7'd17, 11'h600, 3'b010); #1;
        check("bp_ready1", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        cur = mk(1'b0, 7'd14, 11'h0C1, 3'b101); #1;
        check("bp_ready2", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("bp_ready3", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1; #1;
        check("bp_ready4", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Streamed table with random output stalls.
        vecs[0]  = mk(1'b0, 7'd15,  11'h400, 3'b000);
        vecs[1]  = mk(1'b1, 7'd15,  11'h001, 3'b000);
        vecs[2]  = mk(1'b0, 7'd15,  11'h7FF, 3'b100);
        vecs[3]  = mk(1'b0, 7'd30,  11'h7FF, 3'b110);
        vecs[4]  = mk(1'b1, 7'd30,  11'h7FF, 3'b110);
        vecs[5]  = mk(1'b0, 7'd0,   11'h400, 3'b001);
        vecs[6]  = mk(1'b0, 7'd0,   11'h7FF, 3'b111);
        vecs[7]  = mk(1'b0, 7'd1,   11'h400, 3'b000);
        vecs[8]  = mk(1'b0, 7'd15,  11'h400, 3'b101);
        vecs[9]  = mk(1'b1, 7'd20,  11'h555, 3'b011);
        vecs[10] = mk(1'b0, 7'h7D,  11'h0F0, 3'b010);
        vecs[11] = mk(1'b0, 7'd31,  11'h400, 3'b000);
        vecs[12] = mk(1'b0, 7'h3F,  11'h001, 3'b000);
        vecs[13] = mk(1'b0, 7'd5,   11'h3FF, 3'b111);
        vecs[14] = mk(1'b1, 7'd10,  11'h000, 3'b111);
        vecs[15] = mk(1'b0, 7'h76,  11'h7FF, 3'b011);
        for (int i = 0; i < 16; i++) push(vecs[i]);
        drain();

        // Reset in the middle of a stream discards in-flight beats.
        out_ready = 1'b1;
        cur = vecs[9]; in_valid = 1'b1;
        @(posedge clk); #1;
        cur = vecs[2];
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", {16'b0, out_result}, 32'd0);
        check("midrst_flags", {29'b0, out_flags}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        direct("post_rst", mk(1'b1, 7'd15, 11'h400, 3'b000), 16'hBC00, 3'b000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp16_norm_round.md
FP16_NORM_ROUND -- requirements
Module: fp16_norm_round

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  input beat present; in_ready  out  1  stage accepts a beat.
REQ-003 SHALL have ports: in_sign  in  1; in_exp  in  7  two's-complement biased exponent for bit 10 of in_mant; in_mant  in  11  unnormalized significand; in_grs  in  3  guard/round/sticky.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; out_result  out  16  IEEE binary16; out_flags  out  3  {overflow, underflow, inexact}.
REQ-005 SHALL have one clock; reset asynchronous, active-low.

Function
REQ-006 SHALL be a 2-stage pipeline: a beat accepted in cycle N gives out_valid in cycle N+2 when out_ready has stayed 1.
REQ-007 SHALL accept a beat when in_valid&in_ready; output transfers when out_valid&out_ready; out_result/out_flags held stable while out_valid&!out_ready.
REQ-008 SHALL advance stage 2 when it is empty or out_ready=1; SHALL advance stage 1 when it is empty or stage 2 advances; in_ready = stage-1 advance condition (combinational from out_ready).
REQ-009 Stage 1 SHALL compute lzc of in_mant, shift the 14-bit vector {in_mant,in_grs} left by lzc with zero fill, and register e = in_exp - lzc in 8-bit signed arithmetic.
REQ-010 in_mant==0 SHALL produce signed zero {in_sign,15'b0}, flags 0, independent of in_grs.
REQ-011 Stage 2 SHALL round to nearest even: G = guard bit; S = round|sticky; increment when G&(S|lsb); inexact = G|S.
REQ-012 For e>=31 before rounding, SHALL output {sign,5'h1F,10'h0}, overflow=1, inexact=1.
REQ-013 For 1<=e<=30, SHALL pack {sign,e[4:0],m[9:0]}; a rounding carry SHALL clear the fraction and increment e; e reaching 31 SHALL yield infinity with overflow=1, inexact=1.
REQ-014 For e<=0, behaviour SHALL follow REQ-019/REQ-020.
REQ-015 Flags SHALL belong to the beat they accompany and SHALL never be sticky across beats.
REQ-016 Simultaneous output transfer and input accept SHALL lose no beat and preserve order.

Reset
REQ-017 With rst_n low: stage valids=0, in_ready=1 after the reset edge, out_valid=0, out_result=16'h0000, out_flags=3'b000.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight beats immediately, with no output afterwards.

Configuration
REQ-019 With FP16_NORM_SUBNORM_EN defined, SHALL right-shift the significand by 1-e (capped at 14, shifted-out bits ORed into sticky), round per REQ-011, output exponent field 0 (or 1 if rounding reaches 0x400), underflow = inexact.
REQ-020 Without FP16_NORM_SUBNORM_EN, e<=0 SHALL output {sign,15'b0}, underflow=1, inexact=1.

Structure
REQ-021 Package fp16_pkg SHALL hold EXP_BIAS=15, EXP_MAX=31, MANT_W=10, the flags struct typedef, and the lzc width constant.
REQ-022 Leading-zero count SHALL come from an instance of the existing lzd module (11-bit data, 4-bit lzc); no other sub-module.

Verification
REQ-023 exp=15, mant=0x400, grs=0 -> 0x3C00, flags 000, out_valid exactly 2 cycles after accept.
REQ-024 exp=15, mant=0x001, grs=0 -> lzc 10, e=5 -> 0x1400, flags 000.
REQ-025 exp=15, mant=0x7FF, grs=100 -> tie, lsb=1, carry -> 0x4000, inexact=1.
REQ-026 exp=30, mant=0x7FF, grs=110 -> 0x7C00, flags 101; sign=1 -> 0xFC00.
REQ-027 exp=0, mant=0x400, grs=001: with macro -> 0x0200, flags 011; without macro -> 0x0000, flags 011.
REQ-028 Three back-to-back beats with out_ready=0 for 4 cycles -> in_ready falls after 2 beats, third held off, all three emerge in order with no loss; rst_n pulsed mid-stream -> out_valid=0 next cycle and no stale beat.
